mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Bridges the multicycle core's control/datapath and a single-port synchronous memory with configurable read latency. Accepts one instruction-fetch or data request at a time, handles byte-lane alignment for SB/SH/SW and extension for LB/LH/LW/LBU/LHU, and holds results in an instruction register and a memory data register. It replaces the fixed fetch-wait and load-wait states with a ready/valid handshake, so the control FSM stalls for exactly as long as the memory needs.

## Interface
- MEM_LATENCY, 1: cycles from the ACCESS cycle until `mem_rdata` is valid. Legal range is 1..7.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  access request from the control FSM
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = store, 0 = load/fetch
- req_is_data  in  1  0 = instruction fetch, 1 = data access (InstructionOrData)
- req_addr  in  32  byte address
- req_funct3  in  3  access size/sign; ignored for fetches
- req_wdata  in  32  store data (rs2), right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies `resp_valid`: misaligned or illegal access
- instr  out  32  instruction register
- rdata  out  32  extended load data register
- mem_en  out  1  memory enable
- mem_we  out  1  memory write
- mem_addr  out  30  word address, `req_addr[31:2]`
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, DONE.
- **IDLE:**
  - When `req_valid` is high, latch addr, funct3, write, is_data and wdata.
  - Fetches force a word-sized access.
  - Legal request: go to ACCESS. Otherwise: go to DONE with the error flag set.
- **Legal requests:**
  - Loads: funct3 ∈ {000, 001, 010, 100, 101}.
  - Stores: funct3 ∈ {000, 001, 010}.
  - Halfword requires `addr[0]=0`. Word requires `addr[1:0]=0`.
  - A fetch with `req_write=1` is illegal.
- **ACCESS:**
  - Drive `mem_en=1`, `mem_we=write`, `mem_addr`, `mem_be` and `mem_wdata` for exactly this one cycle.
  - Store: go to DONE. Load/fetch: load the latency counter with MEM_LATENCY and go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, sample `mem_rdata` at the clock edge:
    - fetch: write it into `instr`;
    - data: write the extended value into `rdata`.
  - Then go to DONE.
- **DONE:** `resp_valid=1`, `resp_err` equals the latched error flag. Go to IDLE.
- **Byte enables:**
  - SB: `mem_be = 4'b0001 << addr[1:0]`, byte replicated ×4.
  - SH: `addr[1] ? 4'b1100 : 4'b0011`, half replicated ×2.
  - SW: `4'b1111`.
  - Loads/fetches: `4'b1111`.
- **Load extension:**
  - Select the lane from `addr[1:0]`.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
- **Register retention:** `instr` changes only on a successful fetch; `rdata` changes only on a successful data load. Errors and stores update neither.
- **Outputs outside ACCESS:** `mem_en=mem_we=0`, `mem_be=0`. `mem_addr` and `mem_wdata` still reflect the latched values.

## Timing
- **Acceptance:** a request is accepted at edge E, i.e. while `req_valid` and `req_ready` are both high in IDLE.
- **Completion cycle (counting the cycle after E as cycle 1):**
  - store: `resp_valid` in cycle 2;
  - load/fetch: `resp_valid` in cycle `2+MEM_LATENCY`;
  - error: `resp_valid` in cycle 1 with no memory access.
- **Register update:** `instr`/`rdata` are updated at the same edge that enters DONE, so they are valid while `resp_valid` is high.
- **Back-to-back requests:** IDLE follows DONE. A new request can be accepted in the cycle after DONE. Minimum spacing is 3 cycles for stores and `3+MEM_LATENCY` for loads.
- **While busy:** `req_valid` is ignored and `req_ready=0`. The control FSM holds its request.
- **Reset values:**
  - state IDLE;
  - `req_ready=1`;
  - `resp_valid=0`, `resp_err=0`;
  - `instr=32'h00000013` (NOP);
  - `rdata=0`;
  - `mem_en=0`, `mem_we=0`, `mem_be=0`;
  - `mem_addr=0`, `mem_wdata=0`.
- **Reset mid-operation:** asserting `reset` in any state forces all of the above immediately (asynchronous). A pending read result is discarded and no response pulse is produced.

## Structure
- **Package `mem_pkg`:**
  - `mau_state_t` enum;
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - `NOP_INSTR=32'h00000013`.
- **Sub-module `load_extend` (combinational):** inputs are word, `addr[1:0]` and funct3; output is the 32-bit extended value.
- **Top module:** contains the store alignment, legality check, counter and FSM.

## Test plan
- Fetch, addr `0x0000_0010`, `mem_rdata=0x00500093`, MEM_LATENCY=1:
  - `mem_en` high in cycle 1 only;
  - `resp_valid` in cycle 3;
  - `instr=0x00500093`; `rdata` unchanged.
- SB, addr `0x0000_0103`, wdata `0x0000_00AB`:
  - `mem_be=1000`, `mem_wdata=0xABABABAB`, `mem_we=1` for one cycle;
  - `resp_valid` in cycle 2.
- Loads from addr `…02` with `mem_rdata=0x80F1_0000`:
  - LB → `0xFFFF_FFF1`;
  - LBU → `0x0000_00F1`;
  - LH → `0xFFFF_80F1`.
- LW at `0x0000_0006` → `resp_err=1` in cycle 1, `mem_en` never asserted, `rdata` unchanged.
- MEM_LATENCY=3, load accepted: `req_ready=0` for cycles 1–5, `resp_valid` in cycle 5, a second request held through cycle 5 is accepted in cycle 6.
- `reset` asserted during WAIT: same cycle `mem_en=0`, `req_ready=1`, `instr=0x00000013`, no `resp_valid` pulse afterwards.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types, funct3 encodings and the legality helper for the memory access unit.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } mau_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Size/sign/alignment legality; fetches arrive here already forced to word size.
    function automatic logic access_legal(input logic       write,
                                          input logic       is_data,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~write;
            F3_HU:   ok = ~write & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        if (!is_data && write) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response and memory-side bus of the memory access unit.
interface mem_access_unit_if;
    import mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_is_data;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] instr;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Requester side: control FSM plus the memory read port.
    modport master (
        output req_valid, req_write, req_is_data, req_addr, req_funct3, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, instr, rdata,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );

    // The access unit itself.
    modport slave (
        input  req_valid, req_write, req_is_data, req_addr, req_funct3, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, instr, rdata,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed lane of a read word and sign/zero extends it.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension.
    always_comb begin
        byte_sel = word_i[8*addr_lo_i +: 8];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: one fetch or data access at a time, ready/valid towards the core.
//   state  | meaning
//   IDLE   | ready for a request
//   ACCESS | memory strobe cycle
//   WAIT   | counting down read latency
//   DONE   | response pulse
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic               clk,
    input logic               reset,
    mem_access_unit_if.slave  bus
);

    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY);

    mau_state_t  state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic        is_data_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  cnt_q;
    logic [31:0] instr_q;
    logic [31:0] rdata_q;

    logic [2:0]  f3_eff;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        legal;
    logic        accept;
    logic [31:0] ext_data;

    assign accept = (state_q == S_IDLE) && bus.req_valid;

    // Effective size, store lane alignment and legality of the incoming request.
    always_comb begin
        f3_eff  = bus.req_is_data ? bus.req_funct3 : F3_W;
        be_d    = 4'b1111;
        wdata_d = bus.req_wdata;
        if (bus.req_write) begin
            case (f3_eff)
                F3_B: begin
                    be_d    = 4'b0001 << bus.req_addr[1:0];
                    wdata_d = {4{bus.req_wdata[7:0]}};
                end
                F3_H: begin
                    be_d    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{bus.req_wdata[15:0]}};
                end
                default: ;
            endcase
        end
        legal = access_legal(bus.req_write, bus.req_is_data, f3_eff, bus.req_addr[1:0]);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.req_valid) state_d = legal ? S_ACCESS : S_DONE;
            S_ACCESS: state_d = write_q ? S_DONE : S_WAIT;
            S_WAIT:   if (cnt_q == 3'd1) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Request capture at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            funct3_q  <= '0;
            write_q   <= 1'b0;
            is_data_q <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else if (accept) begin
            addr_q    <= bus.req_addr;
            funct3_q  <= f3_eff;
            write_q   <= bus.req_write;
            is_data_q <= bus.req_is_data;
            err_q     <= ~legal;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
        end
    end

    // Read latency down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    cnt_q <= '0;
        else if (state_q == S_ACCESS) cnt_q <= CNT_INIT;
        else if (state_q == S_WAIT)   cnt_q <= cnt_q - 3'd1;
    end

    load_extend u_load_extend (
        .word_i    (bus.mem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .data_o    (ext_data)
    );

    // Instruction and load data registers, written on the edge that enters DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            rdata_q <= '0;
        end else if (state_q == S_WAIT && cnt_q == 3'd1) begin
            if (is_data_q) rdata_q <= ext_data;
            else           instr_q <= bus.mem_rdata;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_DONE);
    assign bus.resp_err   = (state_q == S_DONE) && err_q;
    assign bus.instr      = instr_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_en     = (state_q == S_ACCESS);
    assign bus.mem_we     = (state_q == S_ACCESS) && write_q;
    assign bus.mem_be     = (state_q == S_ACCESS) ? be_q : 4'b0000;
    assign bus.mem_addr   = addr_q[31:2];
    assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: latency 1 and latency 3 instances.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    mem_access_unit_if bus_a ();
    mem_access_unit_if bus_b ();

    mem_access_unit #(.MEM_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mem_access_unit #(.MEM_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Presents a request on instance A for one edge; returns at the negedge of cycle 1.
    task automatic req_a(input logic wr, input logic isd, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd);
        bus_a.req_write   = wr;
        bus_a.req_is_data = isd;
        bus_a.req_addr    = addr;
        bus_a.req_funct3  = f3;
        bus_a.req_wdata   = wd;
        bus_a.req_valid   = 1'b1;
        @(negedge clk);
        bus_a.req_valid   = 1'b0;
    endtask

    task automatic load_a(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
        req_a(1'b0, 1'b1, addr, f3, 32'h0);
        chk({tag, "_en_c1"}, {31'h0, bus_a.mem_en}, 32'd1);
        @(negedge clk);
        chk({tag, "_rv_c2"}, {31'h0, bus_a.resp_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_rv_c3"}, {31'h0, bus_a.resp_valid}, 32'd1);
        chk({tag, "_rdata"}, bus_a.rdata, exp);
        chk({tag, "_instr"}, bus_a.instr, 32'h0050_0093);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset = 1'b1;
        bus_a.req_valid = 0; bus_a.req_write = 0; bus_a.req_is_data = 0;
        bus_a.req_addr = 0; bus_a.req_funct3 = 0; bus_a.req_wdata = 0; bus_a.mem_rdata = 0;
        bus_b.req_valid = 0; bus_b.req_write = 0; bus_b.req_is_data = 0;
        bus_b.req_addr = 0; bus_b.req_funct3 = 0; bus_b.req_wdata = 0; bus_b.mem_rdata = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst_ready", {31'h0, bus_a.req_ready}, 32'd1);
        chk("rst_rv", {31'h0, bus_a.resp_valid}, 32'd0);
        chk("rst_err", {31'h0, bus_a.resp_err}, 32'd0);
        chk("rst_instr", bus_a.instr, 32'h0000_0013);
        chk("rst_rdata", bus_a.rdata, 32'h0);
        chk("rst_en", {31'h0, bus_a.mem_en}, 32'd0);
        chk("rst_we", {31'h0, bus_a.mem_we}, 32'd0);
        chk("rst_be", {28'h0, bus_a.mem_be}, 32'd0);
        chk("rst_addr", {2'b0, bus_a.mem_addr}, 32'd0);
        chk("rst_wdata", bus_a.mem_wdata, 32'h0);

        // Fetch at 0x10, latency 1
        bus_a.mem_rdata = 32'h0050_0093;
        req_a(1'b0, 1'b0, 32'h0000_0010, 3'b111, 32'h0);
        chk("f_en_c1", {31'h0, bus_a.mem_en}, 32'd1);
        chk("f_we_c1", {31'h0, bus_a.mem_we}, 32'd0);
        chk("f_addr_c1", {2'b0, bus_a.mem_addr}, 32'd4);
        chk("f_be_c1", {28'h0, bus_a.mem_be}, 32'hF);
        chk("f_ready_c1", {31'h0, bus_a.req_ready}, 32'd0);
        @(negedge clk);
        chk("f_en_c2", {31'h0, bus_a.mem_en}, 32'd0);
        chk("f_rv_c2", {31'h0, bus_a.resp_valid}, 32'd0);
        @(negedge clk);
        chk("f_rv_c3", {31'h0, bus_a.resp_valid}, 32'd1);
        chk("f_err_c3", {31'h0, bus_a.resp_err}, 32'd0);
        chk("f_instr", bus_a.instr, 32'h0050_0093);
        chk("f_rdata", bus_a.rdata, 32'h0);
        @(negedge clk);
        chk("f_rv_c4", {31'h0, bus_a.resp_valid}, 32'd0);
        chk("f_ready_c4", {31'h0, bus_a.req_ready}, 32'd1);

        // SB at 0x103
        req_a(1'b1, 1'b1, 32'h0000_0103, F3_B, 32'h0000_00AB);
        chk("sb_en_c1", {31'h0, bus_a.mem_en}, 32'd1);
        chk("sb_we_c1", {31'h0, bus_a.mem_we}, 32'd1);
        chk("sb_be_c1", {28'h0, bus_a.mem_be}, 32'h8);
        chk("sb_wdata_c1", bus_a.mem_wdata, 32'hABAB_ABAB);
        chk("sb_addr_c1", {2'b0, bus_a.mem_addr}, 32'h40);
        @(negedge clk);
        chk("sb_rv_c2", {31'h0, bus_a.resp_valid}, 32'd1);
        chk("sb_err_c2", {31'h0, bus_a.resp_err}, 32'd0);
        chk("sb_we_c2", {31'h0, bus_a.mem_we}, 32'd0);
        chk("sb_wdata_c2", bus_a.mem_wdata, 32'hABAB_ABAB);
        chk("sb_rdata", bus_a.rdata, 32'h0);
        @(negedge clk);

        // SH at 0x102
        req_a(1'b1, 1'b1, 32'h0000_0102, F3_H, 32'hFFFF_1234);
        chk("sh_be_c1", {28'h0, bus_a.mem_be}, 32'hC);
        chk("sh_wdata_c1", bus_a.mem_wdata, 32'h1234_1234);
        @(negedge clk);
        chk("sh_rv_c2", {31'h0, bus_a.resp_valid}, 32'd1);
        chk("sh_be_c2", {28'h0, bus_a.mem_be}, 32'h0);
        @(negedge clk);

        // Loads from a word holding 0x80F1_0000
        bus_a.mem_rdata = 32'h80F1_0000;
        load_a("lb",  F3_B,  32'h0000_0202, 32'hFFFF_FFF1);
        load_a("lbu", F3_BU, 32'h0000_0202, 32'h0000_00F1);
        load_a("lh",  F3_H,  32'h0000_0202, 32'hFFFF_80F1);
        load_a("lhu", F3_HU, 32'h0000_0202, 32'h0000_80F1);
        load_a("lb3", F3_B,  32'h0000_0203, 32'hFFFF_FF80);
        load_a("lw",  F3_W,  32'h0000_0200, 32'h80F1_0000);

        // Misaligned LW at 0x6
        req_a(1'b0, 1'b1, 32'h0000_0006, F3_W, 32'h0);
        chk("mis_rv_c1", {31'h0, bus_a.resp_valid}, 32'd1);
        chk("mis_err_c1", {31'h0, bus_a.resp_err}, 32'd1);
        chk("mis_en_c1", {31'h0, bus_a.mem_en}, 32'd0);
        chk("mis_rdata", bus_a.rdata, 32'h80F1_0000);
        @(negedge clk);
        chk("mis_rv_c2", {31'h0, bus_a.resp_valid}, 32'd0);
        chk("mis_ready_c2", {31'h0, bus_a.req_ready}, 32'd1);
        chk("mis_en_c2", {31'h0, bus_a.mem_en}, 32'd0);

        // Fetch with write set
        req_a(1'b1, 1'b0, 32'h0000_0020, F3_W, 32'h0);
        chk("fw_err_c1", {31'h0, bus_a.resp_err}, 32'd1);
        chk("fw_en_c1", {31'h0, bus_a.mem_en}, 32'd0);
        chk("fw_instr", bus_a.instr, 32'h0050_0093);
        @(negedge clk);

        // Store with unsigned size encoding
        req_a(1'b1, 1'b1, 32'h0000_0020, F3_BU, 32'h0);
        chk("sbu_err_c1", {31'h0, bus_a.resp_err}, 32'd1);
        chk("sbu_en_c1", {31'h0, bus_a.mem_en}, 32'd0);
        @(negedge clk);

        // Misaligned SH
        req_a(1'b1, 1'b1, 32'h0000_0021, F3_H, 32'h0);
        chk("shm_err_c1", {31'h0, bus_a.resp_err}, 32'd1);
        @(negedge clk);

        // Latency 3: LW held, then a second request held through DONE
        bus_b.mem_rdata   = 32'hDEAD_BEEF;
        bus_b.req_write   = 1'b0;
        bus_b.req_is_data = 1'b1;
        bus_b.req_addr    = 32'h0000_0020;
        bus_b.req_funct3  = F3_W;
        bus_b.req_valid   = 1'b1;
        @(negedge clk);
        bus_b.req_write   = 1'b1;
        bus_b.req_addr    = 32'h0000_0024;
        bus_b.req_wdata   = 32'h1122_3344;
        chk("l3_en_c1", {31'h0, bus_b.mem_en}, 32'd1);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            chk($sformatf("l3_ready_c%0d", c), {31'h0, bus_b.req_ready}, 32'd0);
            chk($sformatf("l3_rv_c%0d", c), {31'h0, bus_b.resp_valid}, (c == 5) ? 32'd1 : 32'd0);
        end
        chk("l3_rdata", bus_b.rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("l3_ready_c6", {31'h0, bus_b.req_ready}, 32'd1);
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        chk("l3_2nd_en_c7", {31'h0, bus_b.mem_en}, 32'd1);
        chk("l3_2nd_we_c7", {31'h0, bus_b.mem_we}, 32'd1);
        chk("l3_2nd_addr_c7", {2'b0, bus_b.mem_addr}, 32'd9);
        chk("l3_2nd_wdata_c7", bus_b.mem_wdata, 32'h1122_3344);
        @(negedge clk);
        chk("l3_2nd_rv_c8", {31'h0, bus_b.resp_valid}, 32'd1);
        @(negedge clk);

        // Latency 3 fetch to load instr, then reset during WAIT of another fetch
        bus_b.mem_rdata   = 32'hCAFE_0001;
        bus_b.req_write   = 1'b0;
        bus_b.req_is_data = 1'b0;
        bus_b.req_addr    = 32'h0000_0040;
        bus_b.req_valid   = 1'b1;
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("l3f_rv_c5", {31'h0, bus_b.resp_valid}, 32'd1);
        chk("l3f_instr", bus_b.instr, 32'hCAFE_0001);
        @(negedge clk);
        bus_b.mem_rdata = 32'h0BAD_0BAD;
        bus_b.req_valid = 1'b1;
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        @(negedge clk);
        chk("rw_wait_ready", {31'h0, bus_b.req_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("rw_en", {31'h0, bus_b.mem_en}, 32'd0);
        chk("rw_ready", {31'h0, bus_b.req_ready}, 32'd1);
        chk("rw_instr", bus_b.instr, 32'h0000_0013);
        chk("rw_rdata", bus_b.rdata, 32'h0);
        chk("rw_rv", {31'h0, bus_b.resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rw_no_rv_%0d", c), {31'h0, bus_b.resp_valid}, 32'd0);
            chk($sformatf("rw_instr_%0d", c), bus_b.instr, 32'h0000_0013);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
